if_stage: RTL

Instruction fetch stage of the RISC-V core. Holds the PC and issues one word-aligned request at a time to instruction memory over a req/gnt/rvalid handshake. It presents each fetched word, with its PC, to decode and to `imm_gen`, and it accepts PC redirects from the branch unit (taken `beq` target = PC + B-type immediate).

---
 rtl/if_stage_if.sv | 20 ++
 rtl/if_stage.sv | 100 ++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Fetch side issues requests and consumes responses.
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  // Memory side accepts requests and returns data.
  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in
// flight, holds the fetched word for decode, and applies branch redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  imem,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_VALID, S_DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  // PC is always word aligned, so only the upper 30 bits are stored.
  logic [31:2] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_misalign;

  logic w_redir, w_capture, w_consume;

  assign imem.imem_req  = (r_state == S_REQ);
  assign imem.imem_addr = {r_pc, 2'b00};
  assign if_valid       = r_if_valid;
  assign if_instr       = r_if_instr;
  assign if_pc          = r_if_pc;
  assign misalign_err   = r_misalign;

  // Next-state and datapath enables; a redirect overrides everything but IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_redir     = redirect_valid && (r_state != S_IDLE);
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ: begin
        // An accepted request must have its response drained before refetching.
        if (imem.imem_gnt) w_state_nxt = w_redir ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (w_redir)               w_state_nxt = imem.imem_rvalid ? S_REQ : S_DRAIN;
        else if (imem.imem_rvalid) begin
          w_state_nxt = S_VALID;
          w_capture   = 1'b1;
        end
      end
      S_VALID: begin
        if (w_redir)     w_state_nxt = S_REQ;
        else if (!stall) begin
          w_state_nxt = S_REQ;
          w_consume   = 1'b1;
        end
      end
      S_DRAIN: begin
        // Stale response is dropped; a redirect here only moves the PC.
        if (imem.imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // PC, held instruction and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC[31:2];
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
      r_if_pc    <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (w_redir) begin
      r_pc       <= redirect_pc[31:2];
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
      if (redirect_pc[1:0] != 2'b00) r_misalign <= 1'b1;
    end else if (w_capture) begin
      r_pc       <= r_pc + 30'd1;
      r_if_valid <= 1'b1;
      r_if_instr <= imem.imem_rdata;
      r_if_pc    <= {r_pc, 2'b00};
    end else if (w_consume) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end
  end
endmodule
